// File: rtl/conv3x3_stream.sv
// 3x3 convolution stage for the D5M grey/raw pixel stream: pass, Gaussian, Sobel-X, sharpen.
// Two-stage pipeline (window, then arithmetic/clamp); one output pixel per input pixel.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  WAIT_SOF | no frame started since reset; outputs valid-tracked but zeroed
//  RUN      | frame in progress; mode and error flag were latched at last SOF
module conv3x3_stream #(
  parameter int DATA_W  = 12,
  parameter int LINE_W  = 640,
  parameter int COORD_W = 16
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [1:0]         iMODE,
  output logic [DATA_W-1:0]  oDATA,
  output logic               oDVAL,
  output logic               oSAT,
  output logic               oERR
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int GW = DATA_W + 4;
  localparam int SW = DATA_W + 3;
  localparam int HW = DATA_W + 4;
  localparam logic [DATA_W-1:0] PMAX = '1;

  typedef enum logic {WAIT_SOF, RUN} state_t;

  state_t            state_q;
  logic [1:0]        mode_q;

  logic              sof;
  logic              x_ok;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  logic [DATA_W-1:0] lb0 [LINE_W];
  logic [DATA_W-1:0] lb1 [LINE_W];

  logic [DATA_W-1:0] win [3][3];
  logic              s1_vld;
  logic              s1_zero;
  logic [1:0]        s1_mode;

  assign sof    = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
  assign x_ok   = (iX_Cont < COORD_W'(LINE_W));
  assign addr   = iX_Cont[AW-1:0];
  assign lb0_rd = x_ok ? lb0[addr] : '0;
  assign lb1_rd = x_ok ? lb1[addr] : '0;

  // Line-buffer RAM is deliberately left out of reset.
  always_ff @(posedge iCLK) begin
    if (iDVAL && x_ok) begin
      lb0[addr] <= iDATA;
      lb1[addr] <= lb0[addr];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= WAIT_SOF;
      mode_q  <= 2'd0;
      oERR    <= 1'b0;
    end else begin
      case (state_q)
        WAIT_SOF: if (sof) state_q <= RUN;
        RUN:      state_q <= RUN;
        default:  state_q <= WAIT_SOF;
      endcase
      if (sof) begin
        mode_q <= iMODE;
        oERR   <= 1'b0;
      end else if (iDVAL && !x_ok) begin
        oERR   <= 1'b1;
      end
    end
  end

  // Stage 1: window shift plus per-pixel zero/mode tags travelling with it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_vld  <= 1'b0;
      s1_zero <= 1'b1;
      s1_mode <= 2'd0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      s1_vld <= iDVAL;
      if (iDVAL) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= iDATA;
        s1_zero   <= !x_ok || (iX_Cont < COORD_W'(2)) || (iY_Cont < COORD_W'(2)) ||
                     !((state_q == RUN) || sof);
        s1_mode   <= sof ? iMODE : mode_q;
      end
    end
  end

  logic [DATA_W-1:0] tl, t, tr, l, c, r, bl, b, br;
  assign tl = win[0][0];
  assign t  = win[0][1];
  assign tr = win[0][2];
  assign l  = win[1][0];
  assign c  = win[1][1];
  assign r  = win[1][2];
  assign bl = win[2][0];
  assign b  = win[2][1];
  assign br = win[2][2];

  logic [GW-1:0]        g_sum;
  logic [DATA_W+1:0]    r_sum;
  logic [DATA_W+1:0]    l_sum;
  logic signed [SW-1:0] sx;
  logic [SW-1:0]        sx_abs;
  logic [DATA_W+2:0]    c5;
  logic [DATA_W+1:0]    n_sum;
  logic signed [HW-1:0] sh;
  logic [DATA_W-1:0]    k_data;
  logic                 k_sat;

  always_comb begin
    g_sum = {4'b0, tl} + {3'b0, t, 1'b0} + {4'b0, tr} +
            {3'b0, l, 1'b0} + {2'b0, c, 2'b0} + {3'b0, r, 1'b0} +
            {4'b0, bl} + {3'b0, b, 1'b0} + {4'b0, br};
    r_sum  = {2'b0, tr} + {1'b0, r, 1'b0} + {2'b0, br};
    l_sum  = {2'b0, tl} + {1'b0, l, 1'b0} + {2'b0, bl};
    sx     = $signed({1'b0, r_sum}) - $signed({1'b0, l_sum});
    sx_abs = sx[SW-1] ? -sx : sx;
    c5     = {1'b0, c, 2'b0} + {3'b0, c};
    n_sum  = {2'b0, t} + {2'b0, b} + {2'b0, l} + {2'b0, r};
    sh     = $signed({1'b0, c5}) - $signed({2'b0, n_sum});

    k_data = '0;
    k_sat  = 1'b0;
    case (s1_mode)
      2'd0: k_data = c;
      2'd1: k_data = DATA_W'(g_sum >> 4);
      2'd2: begin
        if (|sx_abs[SW-1:DATA_W]) begin
          k_data = PMAX;
          k_sat  = 1'b1;
        end else begin
          k_data = sx_abs[DATA_W-1:0];
        end
      end
      default: begin
        if (sh[HW-1]) begin
          k_data = '0;
          k_sat  = 1'b1;
        end else if (|sh[HW-2:DATA_W]) begin
          k_data = PMAX;
          k_sat  = 1'b1;
        end else begin
          k_data = sh[DATA_W-1:0];
        end
      end
    endcase
  end

  // Stage 2: registered kernel result; border, out-of-range and pre-SOF pixels forced to 0.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
      oSAT  <= 1'b0;
    end else begin
      oDVAL <= s1_vld;
      if (s1_vld) begin
        oDATA <= s1_zero ? '0 : k_data;
        oSAT  <= !s1_zero && k_sat;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: directed and random frames checked against a
// per-pixel arithmetic model of the four kernels over a stored frame image.
module tb_conv3x3_stream;

  localparam int DW   = 12;
  localparam int LW   = 16;
  localparam int CW   = 16;
  localparam int PMAX = 4095;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic [CW-1:0] iX_Cont;
  logic [CW-1:0] iY_Cont;
  logic [1:0]    iMODE;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic          oSAT;
  logic          oERR;

  conv3x3_stream #(.DATA_W(DW), .LINE_W(LW), .COORD_W(CW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iMODE(iMODE),
    .oDATA(oDATA), .oDVAL(oDVAL), .oSAT(oSAT), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;
  int img [16][16];

  bit run_m;
  int mode_m;
  bit err_m;
  bit prev_vld;
  int prev_d, prev_x, prev_y;
  bit prev_s;

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected output for the input pixel at (x,y): centre of the window is (x-1,y-1).
  function automatic void model(int x, int y, output int d, output bit s);
    int tl, t, tr, l, c, r, bl, b, br, v;
    d = 0;
    s = 0;
    if (!run_m || x < 2 || y < 2 || x >= LW) return;
    tl = img[y-2][x-2]; t = img[y-2][x-1]; tr = img[y-2][x];
    l  = img[y-1][x-2]; c = img[y-1][x-1]; r  = img[y-1][x];
    bl = img[y][x-2];   b = img[y][x-1];   br = img[y][x];
    case (mode_m)
      0: d = c;
      1: d = (tl + 2*t + tr + 2*l + 4*c + 2*r + bl + 2*b + br) / 16;
      2: begin
        v = (tr + 2*r + br) - (tl + 2*l + bl);
        if (v < 0) v = -v;
        if (v > PMAX) begin d = PMAX; s = 1; end
        else d = v;
      end
      default: begin
        v = 5*c - t - b - l - r;
        if (v < 0) begin d = 0; s = 1; end
        else if (v > PMAX) begin d = PMAX; s = 1; end
        else d = v;
      end
    endcase
  endfunction

  task automatic do_reset();
    iRST_N = 1'b0;
    iDVAL  = 1'b0;
    #2;
    check("rst_oDVAL", oDVAL, 0);
    check("rst_oDATA", oDATA, 0);
    check("rst_oSAT", oSAT, 0);
    check("rst_oERR", oERR, 0);
    run_m = 0;
    mode_m = 0;
    err_m = 0;
    prev_vld = 0;
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
  endtask

  // One clock: drive an input, then check the output belonging to the previous step's input.
  task automatic step(bit dv, int x, int y, int d, int md);
    int cd;
    bit cs;
    iDVAL   = dv;
    iX_Cont = CW'(x);
    iY_Cont = CW'(y);
    iDATA   = DW'(d);
    iMODE   = 2'(md);
    cd = 0;
    cs = 0;
    if (dv) begin
      if (x == 0 && y == 0) begin
        run_m = 1;
        mode_m = md;
        err_m = 0;
      end
      if (x >= LW) err_m = 1;
      model(x, y, cd, cs);
    end
    @(posedge iCLK);
    #1;
    check("oDVAL", oDVAL, prev_vld);
    if (prev_vld) begin
      check($sformatf("oDATA(%0d,%0d)", prev_x, prev_y), oDATA, prev_d);
      check($sformatf("oSAT(%0d,%0d)", prev_x, prev_y), oSAT, prev_s);
    end
    check("oERR", oERR, err_m);
    prev_vld = dv;
    prev_d = cd;
    prev_s = cs;
    prev_x = x;
    prev_y = y;
  endtask

  task automatic idle();
    step(0, int'($urandom_range(0, LW-1)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, PMAX)), int'($urandom_range(0, 3)));
  endtask

  task automatic frame(int w, int h, int md, int md_late, int sw_row, bit gaps,
                       int rst_row, int oor_row);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y == rst_row && x == 0) do_reset();
        if (gaps && $urandom_range(0, 1) == 1) idle();
        step(1, x, y, img[y][x], (y >= sw_row) ? md_late : md);
      end
      if (y == oor_row) step(1, LW, y, int'($urandom_range(0, PMAX)), md);
    end
    idle();
    idle();
  endtask

  task automatic fill_const(int v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = v;
  endtask

  task automatic fill_rand();
    int k;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        k = int'($urandom_range(0, 3));
        img[y][x] = (k == 0) ? 0 : (k == 1) ? PMAX : int'($urandom_range(0, PMAX));
      end
  endtask

  initial begin
    iRST_N = 1'b0;
    iDVAL = 1'b0;
    iDATA = '0;
    iX_Cont = '0;
    iY_Cont = '0;
    iMODE = 2'd0;
    prev_vld = 0;
    do_reset();

    fill_const(100);
    frame(4, 4, 0, 0, 99, 0, -1, -1);
    frame(8, 8, 1, 1, 99, 0, -1, -1);

    fill_const(0);
    img[5][5] = PMAX;
    frame(12, 12, 1, 1, 99, 0, -1, -1);

    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = (x >= 8) ? PMAX : 0;
    frame(16, 6, 2, 2, 99, 0, -1, -1);

    fill_const(0);
    img[5][5] = PMAX;
    frame(12, 12, 3, 3, 99, 0, -1, -1);
    fill_const(PMAX);
    img[5][5] = 0;
    frame(12, 12, 3, 3, 99, 0, -1, -1);

    fill_rand();
    frame(12, 12, 0, 2, 6, 0, -1, -1);
    fill_rand();
    frame(12, 12, 2, 2, 99, 0, -1, 4);
    fill_rand();
    frame(12, 12, 2, 2, 99, 0, -1, -1);

    for (int m = 0; m < 4; m++) begin
      fill_rand();
      frame(12, 12, m, m, 99, 1, -1, -1);
    end

    fill_rand();
    frame(12, 12, 3, 3, 99, 0, 10, -1);
    frame(12, 12, 3, 3, 99, 0, -1, -1);
    frame(12, 12, 3, 3, 99, 1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
